cross_clk_sync_filt: RTL and testbench
======================================

Name: cross_clk_sync_filt

Overview:
- Multi-channel synchroniser for asynchronous level signals (straps, status lines, slow handshakes) entering the `clk` domain.
- Each channel passes through a LAT-stage flop chain, then a per-channel stability filter that rejects runs shorter than FILT cycles.
- Each channel produces a filtered level plus single-cycle rise and fall pulses; an aggregate change pulse is also provided.
- Successor to the plain 2-flop sync: channel count, filter length and per-channel reset values are all parameterised.

Parameters:
- NCH, 4, number of independent channels (>=1).
- LAT, 2, synchroniser stages per channel (>=2).
- FILT, 4, consecutive stable cycles required before the output follows (>=1; 1 = no filtering).
- INIT, {NCH{1'b0}}, per-channel reset value of q; width NCH.

Ports:
- clk  input  1  destination-domain clock.
- rst  input  1  asynchronous, active-high reset.
- d  input  NCH  asynchronous level inputs, one bit per channel.
- q  output  NCH  synchronised, filtered levels.
- rise  output  NCH  one-cycle pulse on each 0->1 update of q[k].
- fall  output  NCH  one-cycle pulse on each 1->0 update of q[k].
- any_chg  output  1  one-cycle pulse, OR of all rise|fall bits.

Behaviour:
- Interface: one clock (`clk`); reset `rst` is asynchronous and active-high. Every flop clears on `posedge rst` with no clock required.
- Reset values: all sync stages take INIT[k], q=INIT, filter counters=0, rise=fall=0, any_chg=0.
- Sync chain per channel:
  - stage0 <= d[k]; stage i <= stage i-1.
  - s[k] = stage LAT-1.
  - No logic is permitted between stages.
- Filter per channel, with counter cnt of width clog2(FILT) (minimum 1 bit):
  - s==q: cnt<=0, hold q.
  - s!=q and cnt==FILT-1: q<=s, cnt<=0, pulse rise or fall per s.
  - s!=q otherwise: cnt<=cnt+1.
- Latency: a d change stable from before edge 1 reaches q at edge LAT+FILT. Example: LAT=2, FILT=4 gives 6 edges.
- Glitch rejection:
  - A difference between s and q lasting fewer than FILT consecutive cycles never reaches q.
  - The counter restarts whenever s returns to q.
- Pulses:
  - rise[k] and fall[k] are registered and high exactly in the first cycle q[k] holds its new value.
  - rise[k] and fall[k] are never both high.
  - any_chg is registered alongside them in the same cycle.
- Multiple channels may update in the same cycle; pulses assert concurrently.
- Continuous toggling at a period shorter than FILT: q holds its value indefinitely with no pulses.
- Reset mid-filter: q snaps to INIT asynchronously, the counter clears, and any partial run is discarded. After release, a channel whose d differs from INIT updates at edge LAT+FILT.
- Outputs are glitch-free registers. No combinational path from d to any output.

Decomposition:
- Package `sync_pkg`:
  - clog2 constant function.
  - Minimum-legal-value constants for LAT (2) and FILT (1), with elaboration-time checks against them.
- Sub-module `sync_filt_ch`:
  - One channel: chain, counter, q, rise, fall.
  - Parameters LAT, FILT, INIT_BIT.
- Top: generate NCH instances, then register the OR reduction for any_chg.

Test Plan (NCH=4, LAT=2, FILT=4, INIT=4'b0000 unless stated):
- Reset release with d=4'hF held: q=0 and rise=0 during reset; at edge 6 after release q=4'hF, rise=4'hF and any_chg=1 for one cycle, then both 0.
- Glitch, d[0]=1 for 3 cycles then 0: q[0] stays 0; rise[0], fall[0] and any_chg stay 0 throughout.
- Step, d[1] 0->1 held: q[1]=1 at edge 6 with rise[1]=1 for exactly that cycle; d[1] 1->0 later gives fall[1] six edges later.
- Simultaneous, d[2] 0->1 and d[3] 1->0 on the same edge (q[3] preset to 1): rise=4'b0100, fall=4'b1000 and any_chg=1, all in the same cycle.
- Reset mid-filter, assert rst when ch1's counter=2: q=INIT immediately with no clock edge and no pulse. After release with d[1]=1, q[1] rises at edge 6.
- Config LAT=3, FILT=1, INIT=4'b1010: reset gives q=4'b1010; a d[0] step reaches q[0] at edge 4; a 1-cycle pulse on d[0] is passed through.

Source files
------------

// File: rtl/sync_pkg.sv
// Shared constants and helpers for the multi-channel level synchroniser.
package sync_pkg;

  localparam int LAT_MIN  = 2;
  localparam int FILT_MIN = 1;

  // Ceiling log2; returns 0 for v<=1, so callers clamp to a 1-bit minimum.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_filt_ch.sv
// One channel: LAT-deep sync chain, stability filter, registered level and edge pulses.
module sync_filt_ch
  import sync_pkg::*;
#(
  parameter int   LAT      = 2,
  parameter int   FILT     = 4,
  parameter logic INIT_BIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o,
  output logic chg_d_o
);

  localparam int CW = (clog2(FILT) < 1) ? 1 : clog2(FILT);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT - 1);

  if (LAT < LAT_MIN) begin : g_bad_lat
    $error("sync_filt_ch: LAT must be at least %0d", LAT_MIN);
  end
  if (FILT < FILT_MIN) begin : g_bad_filt
    $error("sync_filt_ch: FILT must be at least %0d", FILT_MIN);
  end

  logic [LAT-1:0] chain_q;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           q_q, q_d;
  logic           rise_q, rise_d;
  logic           fall_q, fall_d;
  logic           s;

  assign s = chain_q[LAT-1];

  // Plain flop chain; nothing sits between stages so metastability can settle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain_q <= {LAT{INIT_BIT}};
    else     chain_q <= {chain_q[LAT-2:0], d_i};
  end

  // Filter: follow s only after it has differed from q for FILT straight cycles.
  always_comb begin
    cnt_d  = cnt_q;
    q_d    = q_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (s == q_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      q_d    = s;
      cnt_d  = '0;
      rise_d = s;
      fall_d = ~s;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Filter state and pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      q_q    <= INIT_BIT;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      q_q    <= q_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign q_o     = q_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  // Next-cycle change, so the top can register any_chg in step with the pulses.
  assign chg_d_o = rise_d | fall_d;

endmodule

// File: rtl/cross_clk_sync_filt.sv
// Multi-channel synchroniser with per-channel stability filter and aggregate change pulse.
module cross_clk_sync_filt
  import sync_pkg::*;
#(
  parameter int             NCH  = 4,
  parameter int             LAT  = 2,
  parameter int             FILT = 4,
  parameter logic [NCH-1:0] INIT = {NCH{1'b0}}
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] d,
  output logic [NCH-1:0] q,
  output logic [NCH-1:0] rise,
  output logic [NCH-1:0] fall,
  output logic           any_chg
);

  if (NCH < 1) begin : g_bad_nch
    $error("cross_clk_sync_filt: NCH must be at least 1");
  end

  logic [NCH-1:0] chg_d;
  logic           any_chg_q;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    sync_filt_ch #(
      .LAT      (LAT),
      .FILT     (FILT),
      .INIT_BIT (INIT[k])
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .d_i     (d[k]),
      .q_o     (q[k]),
      .rise_o  (rise[k]),
      .fall_o  (fall[k]),
      .chg_d_o (chg_d[k])
    );
  end

  // Aggregate pulse registered from next-state so it lines up with rise/fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) any_chg_q <= 1'b0;
    else     any_chg_q <= |chg_d;
  end

  assign any_chg = any_chg_q;

endmodule

// File: tb/tb_cross_clk_sync_filt.sv
// Randomised plus directed bench for cross_clk_sync_filt, two configurations side by side.
module tb_cross_clk_sync_filt;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] d;
  logic [3:0] q0, rise0, fall0, q1, rise1, fall1;
  logic       any0, any1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cross_clk_sync_filt u_dut0 (
    .clk(clk), .rst(rst), .d(d), .q(q0), .rise(rise0), .fall(fall0), .any_chg(any0)
  );

  cross_clk_sync_filt #(.NCH(4), .LAT(3), .FILT(1), .INIT(4'b1010)) u_dut1 (
    .clk(clk), .rst(rst), .d(d), .q(q1), .rise(rise1), .fall(fall1), .any_chg(any1)
  );

  // Reference: q[k] takes a new value v at edge n when the d samples at edges
  // n-LAT-FILT+1 .. n-LAT were all v and v differs from q[k]. Samples before
  // reset release count as INIT.
  int         LATV [2] = '{2, 3};
  int         FILTV[2] = '{4, 1};
  logic [3:0] INITV[2] = '{4'b0000, 4'b1010};
  logic [3:0] hist [2][16];
  logic [3:0] mq   [2];
  logic [3:0] mr   [2];
  logic [3:0] mf   [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mq[i] = INITV[i];
      mr[i] = '0;
      mf[i] = '0;
      for (int j = 0; j < 16; j++) hist[i][j] = INITV[i];
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      for (int j = 15; j > 0; j--) hist[i][j] = hist[i][j-1];
      hist[i][0] = d;
      mr[i] = '0;
      mf[i] = '0;
      for (int k = 0; k < 4; k++) begin
        bit stable_diff;
        stable_diff = 1'b1;
        for (int j = LATV[i]; j < LATV[i] + FILTV[i]; j++)
          if (hist[i][j][k] == mq[i][k]) stable_diff = 1'b0;
        if (stable_diff) begin
          mq[i][k] = ~mq[i][k];
          if (mq[i][k]) mr[i][k] = 1'b1;
          else          mf[i][k] = 1'b1;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("q0",    32'(q0),    32'(mq[0]));
    chk("rise0", 32'(rise0), 32'(mr[0]));
    chk("fall0", 32'(fall0), 32'(mf[0]));
    chk("any0",  32'(any0),  32'(|(mr[0] | mf[0])));
    chk("rf0",   32'(rise0 & fall0), 32'd0);
    chk("q1",    32'(q1),    32'(mq[1]));
    chk("rise1", 32'(rise1), 32'(mr[1]));
    chk("fall1", 32'(fall1), 32'(mf[1]));
    chk("any1",  32'(any1),  32'(|(mr[1] | mf[1])));
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge();
    #1;
    check_all();
  endtask

  task automatic step(input logic [3:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      d = v;
      cyc();
    end
  endtask

  initial begin
    logic [3:0] v;
    int         p;
    rst = 1'b1;
    d   = 4'hF;
    model_reset();
    #1;
    check_all();
    for (int i = 0; i < 3; i++) cyc();

    // Release with all inputs high: every channel of config 0 rises at edge 6.
    @(negedge clk);
    rst = 1'b0;
    cyc();
    step(4'hF, 9);
    step(4'h0, 10);

    // Glitch shorter than FILT on ch0.
    step(4'h1, 3);
    step(4'h0, 10);
    // Single-cycle pulse on ch0 (passes in config 1, rejected in config 0).
    step(4'h1, 1);
    step(4'h0, 8);

    // Step up then down on ch1.
    step(4'h2, 10);
    step(4'h0, 10);

    // Simultaneous rise on ch2 and fall on ch3.
    step(4'h8, 10);
    step(4'h4, 10);
    step(4'h0, 10);

    // Reset while ch1 counter is mid-run.
    step(4'h2, 4);
    @(negedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all();
    cyc();
    @(negedge clk);
    rst = 1'b0;
    cyc();
    step(4'h2, 10);

    // Random: blocks alternate between fast toggling and slow steps.
    v = d;
    for (int b = 0; b < 40; b++) begin
      p = (b % 3 == 0) ? 50 : ((b % 3 == 1) ? 20 : 5);
      for (int i = 0; i < 60; i++) begin
        for (int k = 0; k < 4; k++)
          if ($urandom_range(99) < p) v[k] = ~v[k];
        step(v, 1);
      end
      if ($urandom_range(9) == 0) begin
        @(negedge clk);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        cyc();
        @(negedge clk);
        rst = 1'b0;
        cyc();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
